// File: rtl/led_strand_driver.sv
// ---------------------------------------------------------------------------
// led_strand_driver
//
// Consumer end of the LED colour request interface. Requests one LED colour
// at a time from a pattern generator, captures it as a GRB word and
// serialises it MSB first onto a single WS2812-style strand pin. After the
// last LED of the strand it holds the line low for the latch gap, pulses
// frame_done_out and restarts the frame at LED 0.
//
// Optional feature macro: LED_STRAND_DRIVER_BRIGHTNESS_EN
//   When defined, adds brightness_in[7:0]; each captured channel is scaled
//   by (brightness_in + 1) / 256 on the capture cycle.
//
// Ports:
//   clk_in               in   system clock
//   rst_in               in   asynchronous, active-high reset
//   red_in               in   red channel from the generator
//   green_in             in   green channel from the generator
//   blue_in              in   blue channel from the generator
//   color_valid_in       in   generator colour matches the current request
//   brightness_in        in   global brightness (macro builds only)
//   next_led_request_out out  index of the LED whose colour is wanted
//   strand_out           out  serial data to the strand (registered)
//   frame_done_out       out  one-cycle pulse in the last latch-gap cycle
// ---------------------------------------------------------------------------
module led_strand_driver #(
  parameter int NUM_LEDS     = 20,
  parameter int COLOR_WIDTH  = 8,
  parameter int BIT_CYCLES   = 125,
  parameter int HIGH0_CYCLES = 35,
  parameter int HIGH1_CYCLES = 80,
  parameter int RESET_CYCLES = 6000,
  localparam int CounterWidth = $clog2(NUM_LEDS)
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [COLOR_WIDTH-1:0]  red_in,
  input  logic [COLOR_WIDTH-1:0]  green_in,
  input  logic [COLOR_WIDTH-1:0]  blue_in,
  input  logic                    color_valid_in,
`ifdef LED_STRAND_DRIVER_BRIGHTNESS_EN
  input  logic [7:0]              brightness_in,
`endif
  output logic [CounterWidth-1:0] next_led_request_out,
  output logic                    strand_out,
  output logic                    frame_done_out
);

  // Shared cycle counter covers both the bit period and the latch gap.
  localparam int CycMax   = (BIT_CYCLES > RESET_CYCLES) ? BIT_CYCLES : RESET_CYCLES;
  localparam int CycWidth = $clog2(CycMax);
  localparam int BitWidth = $clog2(3 * COLOR_WIDTH + 1);
  localparam int ShiftW   = 3 * COLOR_WIDTH;

  localparam logic [CycWidth-1:0]     BitLast    = CycWidth'(BIT_CYCLES - 1);
  localparam logic [CycWidth-1:0]     High0      = CycWidth'(HIGH0_CYCLES);
  localparam logic [CycWidth-1:0]     High1      = CycWidth'(HIGH1_CYCLES);
  localparam logic [CycWidth-1:0]     GapLast    = CycWidth'(RESET_CYCLES - 1);
  localparam logic [CycWidth-1:0]     GapPreLast = CycWidth'(RESET_CYCLES - 2);
  localparam logic [BitWidth-1:0]     WordLast   = BitWidth'(3 * COLOR_WIDTH - 1);
  localparam logic [CounterWidth-1:0] LedLast    = CounterWidth'(NUM_LEDS - 1);

  typedef enum logic [1:0] {
    FETCH     = 2'd0,
    SHIFT     = 2'd1,
    RESET_GAP = 2'd2
  } state_t;

  state_t                  state,      state_next;
  logic                    settle,     settle_next;
  logic [CounterWidth-1:0] led_idx,    led_next;
  logic [ShiftW-1:0]       shift_reg,  shift_next;
  logic [BitWidth-1:0]     bit_cnt,    bit_next;
  logic [CycWidth-1:0]     cyc_cnt,    cyc_next;
  logic                    strand_next;
  logic                    done_next;
  logic [ShiftW-1:0]       capture_word;

`ifdef LED_STRAND_DRIVER_BRIGHTNESS_EN
  localparam int ProdW = COLOR_WIDTH + 9;

  // (channel * (brightness + 1)) >> 8: 255 is the identity, 0 blanks.
  function automatic logic [COLOR_WIDTH-1:0] scale(
    input logic [COLOR_WIDTH-1:0] chan,
    input logic [7:0]             level
  );
    logic [8:0]       gain;
    logic [ProdW-1:0] prod;
    gain = {1'b0, level} + 9'd1;
    prod = ProdW'(chan) * ProdW'(gain);
    return prod[COLOR_WIDTH+7:8];
  endfunction

  assign capture_word = {scale(green_in, brightness_in),
                         scale(red_in,   brightness_in),
                         scale(blue_in,  brightness_in)};
`else
  assign capture_word = {green_in, red_in, blue_in};
`endif

  assign next_led_request_out = led_idx;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state          <= FETCH;
      settle         <= 1'b1;
      led_idx        <= '0;
      shift_reg      <= '0;
      bit_cnt        <= '0;
      cyc_cnt        <= '0;
      strand_out     <= 1'b0;
      frame_done_out <= 1'b0;
    end else begin
      state          <= state_next;
      settle         <= settle_next;
      led_idx        <= led_next;
      shift_reg      <= shift_next;
      bit_cnt        <= bit_next;
      cyc_cnt        <= cyc_next;
      strand_out     <= strand_next;
      frame_done_out <= done_next;
    end
  end

  always_comb begin
    state_next  = state;
    settle_next = settle;
    led_next    = led_idx;
    shift_next  = shift_reg;
    bit_next    = bit_cnt;
    cyc_next    = cyc_cnt;
    strand_next = 1'b0;
    done_next   = 1'b0;

    unique case (state)
      FETCH: begin
        // The first cycle after entry gives the generator time to see the
        // new index, so a stale valid cannot be mistaken for the new colour.
        if (settle) begin
          settle_next = 1'b0;
        end else if (color_valid_in) begin
          shift_next = capture_word;
          bit_next   = '0;
          cyc_next   = '0;
          state_next = SHIFT;
        end
      end

      SHIFT: begin
        strand_next = (cyc_cnt < (shift_reg[ShiftW-1] ? High1 : High0));
        if (cyc_cnt == BitLast) begin
          cyc_next   = '0;
          shift_next = shift_reg << 1;
          bit_next   = bit_cnt + 1'b1;
          if (bit_cnt == WordLast) begin
            if (led_idx == LedLast) begin
              led_next   = '0;
              state_next = RESET_GAP;
            end else begin
              led_next    = led_idx + 1'b1;
              settle_next = 1'b1;
              state_next  = FETCH;
            end
          end
        end else begin
          cyc_next = cyc_cnt + 1'b1;
        end
      end

      RESET_GAP: begin
        // Registered pulse: raised one cycle early so it is visible during
        // the final gap cycle itself.
        done_next = (cyc_cnt == GapPreLast);
        if (cyc_cnt == GapLast) begin
          cyc_next    = '0;
          settle_next = 1'b1;
          state_next  = FETCH;
        end else begin
          cyc_next = cyc_cnt + 1'b1;
        end
      end

      default: begin
        state_next  = FETCH;
        settle_next = 1'b1;
      end
    endcase
  end

endmodule

// File: doc/led_strand_driver.md
Name: led_strand_driver

Overview:
- Consumer end of the LED colour request interface that the pattern generators serve.
- Issues next_led_request_out, waits for color_valid_in, captures the GRB colour and serialises it onto a single WS2812-style strand pin.
- After the last LED it holds a latch/reset gap, pulses frame_done_out, and restarts at LED 0.
- Sits between any pattern generator and the top-level strand output pin.

Parameters:
- NUM_LEDS, 20, LEDs per strand; must be >= 2.
- COLOR_WIDTH, 8, bits per colour channel.
- BIT_CYCLES, 125, clk_in cycles per serial bit (1.25 us at 100 MHz).
- HIGH0_CYCLES, 35, high time for a '0' bit; must be < HIGH1_CYCLES.
- HIGH1_CYCLES, 80, high time for a '1' bit; must be < BIT_CYCLES.
- RESET_CYCLES, 6000, low time for the latch gap after the last LED.
- CounterWidth (localparam), $clog2(NUM_LEDS), width of the LED index.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous, active-high reset.
- red_in  input  COLOR_WIDTH  red from the generator.
- green_in  input  COLOR_WIDTH  green from the generator.
- blue_in  input  COLOR_WIDTH  blue from the generator.
- color_valid_in  input  1  generator colour corresponds to the current request.
- next_led_request_out  output  CounterWidth  index of the LED whose colour is wanted.
- strand_out  output  1  serial data to the strand.
- frame_done_out  output  1  one-cycle pulse at the end of each latch gap.

Behaviour:
- Clocking and reset: one clock, clk_in. rst_in is asynchronous and active-high.
- Reset values: next_led_request_out=0, strand_out=0, frame_done_out=0, state=FETCH, settle flag set, all counters 0.
- All outputs are registered.

State FETCH:
- next_led_request_out holds led_idx.
- The first cycle after entry (settle cycle) ignores color_valid_in.
- After that, the first cycle with color_valid_in=1 does all of the following:
  - capture shift_reg = {green_in, red_in, blue_in}, sent MSB first (GRB order);
  - clear bit_cnt and cyc_cnt;
  - go to SHIFT.
- strand_out=0 throughout FETCH. There is no timeout. Bounding stalls to less than RESET_CYCLES is the generator's responsibility.

State SHIFT:
- cyc_cnt counts 0..BIT_CYCLES-1.
- strand_out is registered high while cyc_cnt < (shift_reg MSB ? HIGH1_CYCLES : HIGH0_CYCLES), and low otherwise.
- The first high cycle on strand_out appears one cycle after FETCH captures.
- At cyc_cnt=BIT_CYCLES-1: shift left, bit_cnt++, cyc_cnt=0.
- After 3*COLOR_WIDTH bits:
  - if led_idx==NUM_LEDS-1: set led_idx=0 and go to RESET_GAP;
  - otherwise: led_idx++ and go to FETCH.
- next_led_request_out updates in the same cycle the state changes.

State RESET_GAP:
- strand_out=0 for exactly RESET_CYCLES cycles.
- In the last gap cycle, frame_done_out=1 for one cycle. The state then goes to FETCH (with settle) at led_idx=0.

Protocol rules:
- next_led_request_out never changes while in FETCH before capture.
- color_valid_in is don't-care outside FETCH.
- Colour inputs are sampled only on the capture cycle.

Boundaries:
- led_idx wraps NUM_LEDS-1 -> 0 only via RESET_GAP.
- Reset asserted mid-bit forces strand_out low asynchronously and aborts the frame. The next frame starts at LED 0.
- color_valid_in held high continuously still costs the settle cycle per LED.

Widths:
- cyc_cnt is $clog2(max(BIT_CYCLES, RESET_CYCLES)) bits and is reused as the gap counter.
- bit_cnt is $clog2(3*COLOR_WIDTH+1) bits.

Optional Feature:
- Macro: LED_STRAND_DRIVER_BRIGHTNESS_EN.
- When defined:
  - adds input brightness_in[7:0];
  - on capture, each channel is stored as (channel * (brightness_in + 1)) >> 8, truncated to COLOR_WIDTH;
  - brightness_in is sampled on the capture cycle only;
  - 255 passes colours unchanged and 0 yields all-zero colours.
- When undefined: the port is absent and colours are stored unmodified.

Test Plan:
- Single LED waveform: NUM_LEDS=2, generator returns G=0x80, R=0x00, B=0x01 with valid one cycle after request → first bit high 80 cycles then low 45; next 22 bits high 35 cycles each; last bit high 80; total 24*125 cycles of SHIFT.
- Delayed valid: color_valid_in held low 10 cycles after the request changes → strand_out stays 0 and next_led_request_out stays constant; capture occurs on the first valid cycle, and strand_out rises exactly one cycle later.
- Frame wrap: NUM_LEDS=3 → requests 0,1,2, then RESET_GAP of 6000 low cycles, one frame_done_out pulse, then request returns to 0.
- Settle rule: color_valid_in tied to 1 → capture never occurs in the first cycle after a request change; SHIFT entry is 2 cycles after the index change.
- Reset mid-operation: assert rst_in during bit 7 of LED 1 → strand_out=0 and request=0 immediately (without waiting for a clock edge); after release, the sequence restarts at LED 0 with the settle cycle.
- Brightness (macro on): brightness_in=0x7F, colour 0xFF/0x40/0x02 → captured 0x7F/0x20/0x01, verified via the serial bit pattern.
